// File: rtl/management_bus_fabric_pkg.sv
// Shared types and helpers for the management bus fabric: read FSM states,
// window decode and the saturating error-counter increment.
package mgmt_bus_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_ERR
  } rd_state_t;

  // Window index of a zero-extended address; the caller compares it to NUM_PORTS.
  function automatic logic [31:0] port_index(input logic [31:0] addr,
                                             input int unsigned port_bits);
    return addr >> port_bits;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value,
                                          input logic [1:0]  amount);
    logic [16:0] sum;
    sum = {1'b0, value} + 17'(amount);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/management_bus_fabric_if.sv
// Upstream byte-wide rd/wr bus between the QSPI management bridge (master)
// and the fabric (slave).
interface management_bus_fabric_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_valid, rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_valid, rd_data
  );

endinterface

// File: rtl/management_bus_fabric.sv
// Address-decoding fabric: one upstream rd/wr bus fanned out to NUM_PORTS
// register-bank windows, with read timeout, unmapped handling and error counters.
module management_bus_fabric
  import mgmt_bus_pkg::*;
#(
  parameter int unsigned           NUM_PORTS      = 4,
  parameter int unsigned           ADDR_WIDTH     = 16,
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           PORT_ADDR_BITS = 12,
  parameter int unsigned           RD_TIMEOUT     = 255,
  parameter int unsigned           WR_PIPE        = 1,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 'hEE
) (
  input  logic                            clk,
  input  logic                            rst,
  management_bus_fabric_if.slave          up,
  output logic [NUM_PORTS-1:0]            p_rd_en,
  output logic [PORT_ADDR_BITS-1:0]       p_rd_addr,
  input  logic [NUM_PORTS-1:0]            p_rd_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_rd_data,
  output logic [NUM_PORTS-1:0]            p_wr_en,
  output logic [PORT_ADDR_BITS-1:0]       p_wr_addr,
  output logic [DATA_WIDTH-1:0]           p_wr_data,
  output logic [15:0]                     err_unmapped,
  output logic [15:0]                     err_timeout,
  output logic [15:0]                     err_overrun,
  output logic [ADDR_WIDTH-1:0]           err_last_addr
);

  // An index at or above NUM_PORTS matches no bit, so an all-zero result means unmapped.
  function automatic logic [NUM_PORTS-1:0] decode_oh(input logic [31:0] idx);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_PORTS; i++) oh[i] = (idx == 32'(i));
    return oh;
  endfunction

  rd_state_t             state;
  logic [15:0]           timer;
  logic [NUM_PORTS-1:0]  sel_oh;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  logic [NUM_PORTS-1:0]  rd_oh;
  logic [NUM_PORTS-1:0]  wr_oh;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  rd_unmapped_ev;
  logic                  wr_unmapped_ev;
  logic                  overrun_ev;
  logic                  timeout_ev;

  assign rd_oh = decode_oh(port_index(32'(up.rd_addr), PORT_ADDR_BITS));
  assign wr_oh = decode_oh(port_index(32'(up.wr_addr), PORT_ADDR_BITS));

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_valid = |(p_rd_valid & sel_oh);
    sel_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (sel_oh[i]) sel_data = p_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rd_unmapped_ev = up.rd_en && (state == RD_IDLE) && !(|rd_oh);
  assign overrun_ev     = up.rd_en && (state != RD_IDLE);
  assign wr_unmapped_ev = up.wr_en && !(|wr_oh);
  // Returned data beats a timeout that would fire in the same cycle.
  assign timeout_ev     = (state == RD_WAIT) && !sel_valid && (timer == 16'(RD_TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RD_IDLE;
      timer         <= '0;
      sel_oh        <= '0;
      rd_addr_q     <= '0;
      p_rd_en       <= '0;
      p_rd_addr     <= '0;
      up.rd_valid   <= 1'b0;
      up.rd_data    <= '0;
      err_unmapped  <= '0;
      err_timeout   <= '0;
      err_overrun   <= '0;
      err_last_addr <= '0;
    end else begin
      p_rd_en     <= '0;
      up.rd_valid <= 1'b0;

      unique case (state)
        RD_IDLE: begin
          if (up.rd_en) begin
            if (|rd_oh) begin
              p_rd_en   <= rd_oh;
              sel_oh    <= rd_oh;
              p_rd_addr <= up.rd_addr[PORT_ADDR_BITS-1:0];
              rd_addr_q <= up.rd_addr;
              timer     <= '0;
              state     <= RD_WAIT;
            end else begin
              state <= RD_ERR;
            end
          end
        end
        RD_WAIT: begin
          if (sel_valid) begin
            up.rd_valid <= 1'b1;
            up.rd_data  <= sel_data;
            state       <= RD_IDLE;
          end else if (timeout_ev) begin
            up.rd_valid <= 1'b1;
            up.rd_data  <= ERR_DATA;
            state       <= RD_IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        RD_ERR: begin
          up.rd_valid <= 1'b1;
          up.rd_data  <= ERR_DATA;
          state       <= RD_IDLE;
        end
        default: state <= RD_IDLE;
      endcase

      err_unmapped <= sat_inc(err_unmapped, {1'b0, rd_unmapped_ev} + {1'b0, wr_unmapped_ev});
      err_timeout  <= sat_inc(err_timeout, {1'b0, timeout_ev});
      err_overrun  <= sat_inc(err_overrun, {1'b0, overrun_ev});

      // Read-side errors take precedence over a simultaneous unmapped write.
      if (rd_unmapped_ev || overrun_ev) err_last_addr <= up.rd_addr;
      else if (timeout_ev)              err_last_addr <= rd_addr_q;
      else if (wr_unmapped_ev)          err_last_addr <= up.wr_addr;
    end
  end

  if (WR_PIPE != 0) begin : g_wr_pipe
    always_ff @(posedge clk) begin
      if (rst) begin
        p_wr_en   <= '0;
        p_wr_addr <= '0;
        p_wr_data <= '0;
      end else begin
        p_wr_en <= up.wr_en ? wr_oh : '0;
        if (up.wr_en && |wr_oh) begin
          p_wr_addr <= up.wr_addr[PORT_ADDR_BITS-1:0];
          p_wr_data <= up.wr_data;
        end
      end
    end
  end else begin : g_wr_comb
    always_comb begin
      p_wr_en   = (up.wr_en && !rst) ? wr_oh : '0;
      p_wr_addr = rst ? '0 : up.wr_addr[PORT_ADDR_BITS-1:0];
      p_wr_data = rst ? '0 : up.wr_data;
    end
  end

endmodule

// File: tb/tb_management_bus_fabric.sv
// Directed bench for management_bus_fabric: dut_b (4 ports, combinational
// writes) and dut_a (3 ports, pipelined writes), both with RD_TIMEOUT = 10.
module tb_management_bus_fabric;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  management_bus_fabric_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_a ();
  management_bus_fabric_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_b ();

  logic [2:0]  a_p_rd_en, a_p_rd_valid, a_p_wr_en;
  logic [11:0] a_p_rd_addr, a_p_wr_addr;
  logic [23:0] a_p_rd_data;
  logic [7:0]  a_p_wr_data;
  logic [15:0] a_err_unmapped, a_err_timeout, a_err_overrun, a_err_last_addr;

  logic [3:0]  b_p_rd_en, b_p_rd_valid, b_p_wr_en;
  logic [11:0] b_p_rd_addr, b_p_wr_addr;
  logic [31:0] b_p_rd_data;
  logic [7:0]  b_p_wr_data;
  logic [15:0] b_err_unmapped, b_err_timeout, b_err_overrun, b_err_last_addr;

  management_bus_fabric #(
    .NUM_PORTS(3), .ADDR_WIDTH(16), .DATA_WIDTH(8), .PORT_ADDR_BITS(12),
    .RD_TIMEOUT(10), .WR_PIPE(1), .ERR_DATA(8'hEE)
  ) dut_a (
    .clk(clk), .rst(rst), .up(bus_a),
    .p_rd_en(a_p_rd_en), .p_rd_addr(a_p_rd_addr), .p_rd_valid(a_p_rd_valid),
    .p_rd_data(a_p_rd_data), .p_wr_en(a_p_wr_en), .p_wr_addr(a_p_wr_addr),
    .p_wr_data(a_p_wr_data), .err_unmapped(a_err_unmapped), .err_timeout(a_err_timeout),
    .err_overrun(a_err_overrun), .err_last_addr(a_err_last_addr)
  );

  management_bus_fabric #(
    .NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(8), .PORT_ADDR_BITS(12),
    .RD_TIMEOUT(10), .WR_PIPE(0), .ERR_DATA(8'hEE)
  ) dut_b (
    .clk(clk), .rst(rst), .up(bus_b),
    .p_rd_en(b_p_rd_en), .p_rd_addr(b_p_rd_addr), .p_rd_valid(b_p_rd_valid),
    .p_rd_data(b_p_rd_data), .p_wr_en(b_p_wr_en), .p_wr_addr(b_p_wr_addr),
    .p_wr_data(b_p_wr_data), .err_unmapped(b_err_unmapped), .err_timeout(b_err_timeout),
    .err_overrun(b_err_overrun), .err_last_addr(b_err_last_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cycles;

  initial begin
    rst = 1'b1;
    bus_a.rd_en = 1'b0; bus_a.rd_addr = '0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_b.rd_en = 1'b0; bus_b.rd_addr = '0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    a_p_rd_valid = '0; a_p_rd_data = '0;
    b_p_rd_valid = '0; b_p_rd_data = '0;
    repeat (3) tick();

    check("reset a rd_valid", 32'(bus_a.rd_valid), 0);
    check("reset a rd_data", 32'(bus_a.rd_data), 0);
    check("reset a p_rd_en", 32'(a_p_rd_en), 0);
    check("reset a p_wr_en", 32'(a_p_wr_en), 0);
    check("reset a err_unmapped", 32'(a_err_unmapped), 0);
    check("reset b p_rd_addr", 32'(b_p_rd_addr), 0);
    check("reset b err_last_addr", 32'(b_err_last_addr), 0);
    rst = 1'b0;
    tick();

    // Mapped read on b: port 2 answers three cycles after p_rd_en.
    bus_b.rd_en = 1'b1; bus_b.rd_addr = 16'h2034;
    tick();                                                   // N+1
    bus_b.rd_en = 1'b0;
    check("map p_rd_en", 32'(b_p_rd_en), 32'h4);
    check("map p_rd_addr", 32'(b_p_rd_addr), 32'h034);
    b_p_rd_valid = 4'b0001; b_p_rd_data = 32'h0000_0011;     // foreign port, ignored
    tick();                                                   // N+2
    check("map p_rd_en one cycle", 32'(b_p_rd_en), 0);
    b_p_rd_valid = '0;
    tick();                                                   // N+3
    check("map foreign valid ignored", 32'(bus_b.rd_valid), 0);
    tick();                                                   // N+4
    b_p_rd_valid = 4'b0100; b_p_rd_data = 32'h005A_0000;
    tick();                                                   // N+5
    b_p_rd_valid = '0;
    check("map rd_valid", 32'(bus_b.rd_valid), 1);
    check("map rd_data", 32'(bus_b.rd_data), 32'h5A);
    tick();
    check("map rd_valid one cycle", 32'(bus_b.rd_valid), 0);

    // Minimum latency read, then a new rd_en in the rd_valid cycle.
    bus_b.rd_en = 1'b1; bus_b.rd_addr = 16'h0005;
    tick();                                                   // N+1
    bus_b.rd_en = 1'b0;
    b_p_rd_valid = 4'b0001; b_p_rd_data = 32'h0000_003C;
    tick();                                                   // N+2
    b_p_rd_valid = '0;
    check("minlat rd_valid", 32'(bus_b.rd_valid), 1);
    check("minlat rd_data", 32'(bus_b.rd_data), 32'h3C);
    bus_b.rd_en = 1'b1; bus_b.rd_addr = 16'h3001;
    tick();
    bus_b.rd_en = 1'b0;
    check("b2b p_rd_en", 32'(b_p_rd_en), 32'h8);
    check("b2b no overrun", 32'(b_err_overrun), 0);
    b_p_rd_valid = 4'b1000; b_p_rd_data = 32'h7700_0000;
    tick();
    b_p_rd_valid = '0;
    check("b2b rd_data", 32'(bus_b.rd_data), 32'h77);
    tick();

    // Timeout on b: port 1 never answers.
    bus_b.rd_en = 1'b1; bus_b.rd_addr = 16'h1010;
    tick();
    bus_b.rd_en = 1'b0;
    cycles = 1;
    while (!bus_b.rd_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    check("tmo latency", 32'(cycles), 12);
    check("tmo rd_data", 32'(bus_b.rd_data), 32'hEE);
    check("tmo err_timeout", 32'(b_err_timeout), 1);
    check("tmo err_last_addr", 32'(b_err_last_addr), 32'h1010);
    tick();
    tick();
    b_p_rd_valid = 4'b0010; b_p_rd_data = 32'h0000_9900;
    tick();
    b_p_rd_valid = '0;
    check("tmo late valid ignored", 32'(bus_b.rd_valid), 0);

    // Data arriving in the cycle the timeout would fire wins.
    bus_b.rd_en = 1'b1; bus_b.rd_addr = 16'h1020;
    tick();                                                   // N+1
    bus_b.rd_en = 1'b0;
    repeat (10) tick();                                       // N+11
    b_p_rd_valid = 4'b0010; b_p_rd_data = 32'h0000_6600;
    tick();                                                   // N+12
    b_p_rd_valid = '0;
    check("tmo edge rd_data", 32'(bus_b.rd_data), 32'h66);
    check("tmo edge no count", 32'(b_err_timeout), 1);
    tick();

    // Combinational write on b concurrent with an outstanding read.
    bus_b.rd_en = 1'b1; bus_b.rd_addr = 16'h0100;
    tick();
    bus_b.rd_en = 1'b0;
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 16'h1FFF; bus_b.wr_data = 8'hA5;
    #1;
    check("wr0 p_wr_en", 32'(b_p_wr_en), 32'h2);
    check("wr0 p_wr_addr", 32'(b_p_wr_addr), 32'hFFF);
    check("wr0 p_wr_data", 32'(b_p_wr_data), 32'hA5);
    tick();
    bus_b.wr_en = 1'b0;
    #1;
    check("wr0 p_wr_en drop", 32'(b_p_wr_en), 0);
    b_p_rd_valid = 4'b0001; b_p_rd_data = 32'h0000_0042;
    tick();
    b_p_rd_valid = '0;
    check("wr0 concurrent read", 32'(bus_b.rd_data), 32'h42);
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 16'hF000; bus_b.wr_data = 8'h01;
    #1;
    check("wr0 unmapped no strobe", 32'(b_p_wr_en), 0);
    tick();
    bus_b.wr_en = 1'b0;
    check("wr0 unmapped count", 32'(b_err_unmapped), 1);
    check("wr0 unmapped addr", 32'(b_err_last_addr), 32'hF000);

    // Unmapped read on a (3 ports).
    bus_a.rd_en = 1'b1; bus_a.rd_addr = 16'h3000;
    tick();                                                   // N+1
    bus_a.rd_en = 1'b0;
    check("unm no p_rd_en", 32'(a_p_rd_en), 0);
    check("unm rd_valid early", 32'(bus_a.rd_valid), 0);
    tick();                                                   // N+2
    check("unm rd_valid", 32'(bus_a.rd_valid), 1);
    check("unm rd_data", 32'(bus_a.rd_data), 32'hEE);
    check("unm count", 32'(a_err_unmapped), 1);
    check("unm last addr", 32'(a_err_last_addr), 32'h3000);

    // Pipelined write on a.
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 16'h1FFF; bus_a.wr_data = 8'hA5;
    #1;
    check("wr1 not yet", 32'(a_p_wr_en), 0);
    tick();
    bus_a.wr_en = 1'b0;
    check("wr1 p_wr_en", 32'(a_p_wr_en), 32'h2);
    check("wr1 p_wr_addr", 32'(a_p_wr_addr), 32'hFFF);
    check("wr1 p_wr_data", 32'(a_p_wr_data), 32'hA5);
    tick();
    check("wr1 p_wr_en drop", 32'(a_p_wr_en), 0);

    // Same-cycle unmapped read and unmapped write.
    bus_a.rd_en = 1'b1; bus_a.rd_addr = 16'h3ABC;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 16'hC000; bus_a.wr_data = 8'h11;
    tick();
    bus_a.rd_en = 1'b0; bus_a.wr_en = 1'b0;
    check("dual unm count", 32'(a_err_unmapped), 3);
    check("dual unm last addr", 32'(a_err_last_addr), 32'h3ABC);
    check("dual unm no p_wr_en", 32'(a_p_wr_en), 0);
    tick();
    tick();

    // Overrun in WAIT, then reset mid-read.
    bus_a.rd_en = 1'b1; bus_a.rd_addr = 16'h0010;
    tick();
    bus_a.rd_en = 1'b1; bus_a.rd_addr = 16'h1020;
    check("ovr first p_rd_en", 32'(a_p_rd_en), 32'h1);
    tick();
    bus_a.rd_en = 1'b0;
    check("ovr no second p_rd_en", 32'(a_p_rd_en), 0);
    check("ovr count", 32'(a_err_overrun), 1);
    check("ovr last addr", 32'(a_err_last_addr), 32'h1020);
    rst = 1'b1;
    tick();
    check("rst rd_valid", 32'(bus_a.rd_valid), 0);
    check("rst p_rd_addr", 32'(a_p_rd_addr), 0);
    check("rst p_wr_addr", 32'(a_p_wr_addr), 0);
    check("rst err_overrun", 32'(a_err_overrun), 0);
    check("rst err_unmapped", 32'(a_err_unmapped), 0);
    rst = 1'b0;
    a_p_rd_valid = 3'b001; a_p_rd_data = 24'h0000_55;
    tick();
    a_p_rd_valid = '0;
    tick();
    check("rst aborted read", 32'(bus_a.rd_valid), 0);

    // Saturation: 70000 unmapped writes.
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 16'h3000; bus_a.wr_data = 8'h00;
    repeat (65534) tick();
    check("sat before", 32'(a_err_unmapped), 32'hFFFE);
    repeat (2) tick();
    check("sat reach", 32'(a_err_unmapped), 32'hFFFF);
    repeat (70000 - 65536) tick();
    bus_a.wr_en = 1'b0;
    tick();
    check("sat hold", 32'(a_err_unmapped), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/management_bus_fabric.md
# management_bus_fabric

Parametrised address-decoding fabric between the QSPI management bridge and the register-bank peripherals of the management subsystem. It fans one upstream byte-wide rd/wr bus out to NUM_PORTS peripheral windows, with optional write pipelining and a registered read-return path. It handles unmapped addresses and read timeouts, and keeps saturating error counters, so one misbehaving register bank can no longer hang the bridge. It replaces ad-hoc pipeline registers and single-target wiring in subsystem containers.

## Interface
Parameters:
- NUM_PORTS, 4: downstream windows; 1..16.
- ADDR_WIDTH, 16: upstream address width.
- DATA_WIDTH, 8: data width.
- PORT_ADDR_BITS, 12: window size is 2^PORT_ADDR_BITS bytes; port index = addr[ADDR_WIDTH-1:PORT_ADDR_BITS].
- RD_TIMEOUT, 255: cycles to wait for p_rd_valid before error; 2..65535.
- WR_PIPE, 1: 1 = register the write path, 0 = write path combinational.
- ERR_DATA, 'hEE: data returned on unmapped or timed-out reads.

Ports:
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  single clock (sys_clk domain).
- rst  in  1  synchronous active-high reset.
- rd_en  in  1  upstream read strobe, one cycle.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_valid  out  1  read data valid, one cycle.
- rd_data  out  DATA_WIDTH  read data.
- wr_en  in  1  upstream write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- p_rd_en  out  NUM_PORTS  one-hot read strobe.
- p_rd_addr  out  PORT_ADDR_BITS  shared window-relative read address.
- p_rd_valid  in  NUM_PORTS  per-port read valid.
- p_rd_data  in  NUM_PORTS*DATA_WIDTH  per-port read data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- p_wr_en  out  NUM_PORTS  one-hot write strobe.
- p_wr_addr  out  PORT_ADDR_BITS  shared write address.
- p_wr_data  out  DATA_WIDTH  shared write data.
- err_unmapped  out  16  saturating count of unmapped reads and writes.
- err_timeout  out  16  saturating count of read timeouts.
- err_overrun  out  16  saturating count of rd_en received while a read is outstanding.
- err_last_addr  out  ADDR_WIDTH  address of the most recent error.

## Operation
- Reset: every output is 0 (rd_data, p_*_addr, p_wr_data and counters included); read FSM goes to IDLE; the timeout counter clears. Reset during an outstanding read aborts it and emits no rd_valid.
- Read FSM, state IDLE: on rd_en, decode the port index.
  - Index < NUM_PORTS: assert that port's p_rd_en and latch p_rd_addr; go to WAIT.
  - Otherwise: go to ERR, which returns ERR_DATA, increments err_unmapped and goes back to IDLE.
- Read FSM, state WAIT: the selected port's p_rd_valid returns its data on rd_data/rd_valid; go to IDLE. p_rd_valid from any non-selected port is ignored.
- Timeout: when the counter reaches RD_TIMEOUT in WAIT, return ERR_DATA, increment err_timeout and go to IDLE. A p_rd_valid arriving later is ignored.
- rd_en outside IDLE: dropped, with no downstream strobe; increment err_overrun.
- Writes are independent of the read FSM and are never blocked. A mapped write produces a one-hot p_wr_en. An unmapped write is dropped and increments err_unmapped.
- Same-cycle unmapped read and unmapped write: err_unmapped increments by 2 (saturating); err_last_addr takes rd_addr.
- All counters saturate at 16'hFFFF. err_last_addr updates on every error.

## Timing
- rd_en at cycle N: p_rd_en is high for exactly one cycle at N+1.
- p_rd_valid at cycle M: rd_valid and rd_data at M+1.
- Minimum mapped read latency is 2 cycles (p_rd_valid arriving at N+1).
- Unmapped read: rd_valid at N+2.
- Timeout: rd_valid at N+1+RD_TIMEOUT+1.
- p_rd_valid in the same cycle the timeout fires: the data wins and no timeout is counted.
- Next accepted rd_en: the cycle after rd_valid, or the same cycle as rd_valid.
- Writes: p_wr_en/addr/data follow wr_en at N+WR_PIPE.
- One read outstanding at most.

## Structure
- Shared package mgmt_bus_pkg holds:
  - enum rd_state_t {RD_IDLE, RD_WAIT, RD_ERR};
  - a function port_index(addr) for decode;
  - the saturating-increment function, shared by all three counters.
- Single module; no sub-module is warranted.

## Test plan
- Mapped read: rd_addr 16'h2034, port 2 returns 8'h5A three cycles after p_rd_en -> p_rd_en = 4'b0100 with p_rd_addr = 12'h034; rd_data 8'h5A one cycle after p_rd_valid.
- Unmapped read: NUM_PORTS = 3, rd_addr 16'h3000 -> no p_rd_en; rd_valid at N+2 with 8'hEE; err_unmapped = 1; err_last_addr = 16'h3000.
- Timeout: RD_TIMEOUT = 10, port never answers -> rd_valid at N+12 with 8'hEE; err_timeout = 1. A p_rd_valid two cycles after that -> no second rd_valid.
- Overrun, then reset mid-read: second rd_en in WAIT -> err_overrun = 1 and no second p_rd_en. rst asserted in WAIT -> no rd_valid, all outputs 0.
- Writes with WR_PIPE 0 and 1: write 16'h1FFF/8'hA5 -> p_wr_en = 4'b0010, p_wr_addr = 12'hFFF, at N and N+1 respectively; concurrent with an outstanding read, both complete.
- Saturation: force 70000 unmapped writes -> err_unmapped holds at 16'hFFFF.
